aes_block_tx_ctrl: RTL and testbench
====================================

# aes_block_tx_ctrl

Transmit scheduler between the AES core and `uart_tx`. It accepts 128-bit result blocks and single status bytes from two requesters, arbitrates between them, and serializes each grant into `uart_tx` byte transfers using the start/done-tick handshake. It guarantees that a block is never interleaved with other traffic, and it recovers from a stalled transmitter with a watchdog.

## Interface
Parameters:
- `GAP_CYCLES`, default 0: idle cycles inserted between consecutive bytes of one block.
- `TIMEOUT_CYCLES`, default 16384: maximum cycles in WAIT without `tx_done_tick_i`. A value of 0 disables the watchdog.
- `MSB_FIRST`, default 1: 1 sends `blk_data_i[127:120]` first; 0 sends `[7:0]` first.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_i` in 1: synchronous, active-high reset.
- `blk_valid_i` in 1: block request.
- `blk_data_i` in 128: block payload, sampled on accept.
- `blk_ready_o` out 1: block accept qualifier.
- `byte_valid_i` in 1: status byte request.
- `byte_data_i` in 8: status byte, sampled on accept.
- `byte_ready_o` out 1: byte accept qualifier.
- `tx_din_o` out 8: byte to `uart_tx`.
- `tx_start_o` out 1: one-cycle start pulse to `uart_tx`.
- `tx_done_tick_i` in 1: done tick from `uart_tx`.
- `busy_o` out 1: high in any state other than IDLE.
- `blk_done_tick_o` out 1: one-cycle pulse after the 16th byte of a block completes.
- `timeout_tick_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States are IDLE, START, WAIT and GAP.
- **IDLE**
  - `blk_ready_o` is high only when `byte_valid_i` is low. `byte_ready_o` is high whenever the state is IDLE. Both ready signals are decoded combinationally from state and valids.
  - If both requesters are valid, the byte wins. The block waits; its data must stay stable while valid.
  - On accept: payload goes into the shift register (block) or the low byte (byte), `is_blk` is set, `byte_idx` is cleared, and the next state is START.
- **START**
  - `tx_start_o` is high for exactly this cycle.
  - `tx_din_o` shows the current byte. The current byte is the top byte of the shift register if `MSB_FIRST`, otherwise the bottom byte.
  - Next state is WAIT.
- **WAIT**
  - `tx_din_o` holds its value.
  - The watchdog counter increments every cycle.
  - On `tx_done_tick_i`:
    - If `is_blk` and `byte_idx` < 15: shift the register by 8 bits, increment `byte_idx`, and go to GAP. If `GAP_CYCLES` = 0, go directly to START.
    - Otherwise: go to IDLE. If `is_blk`, pulse `blk_done_tick_o` in the same cycle as the transition.
  - If the counter reaches `TIMEOUT_CYCLES` with no done tick: pulse `timeout_tick_o`, abandon the transfer, clear `byte_idx` and `is_blk`, and go to IDLE. No `blk_done_tick_o` is issued.
- **GAP**
  - Counts `GAP_CYCLES` cycles, then goes to START.
- `tx_done_tick_i` is ignored outside WAIT.
- `byte_idx` is 4 bits. It never wraps, because the 16th byte always exits to IDLE.
- The watchdog counter is 15 bits, saturating. It clears on every entry to START.

## Timing
- **Reset values:** `tx_start_o`=0, `tx_din_o`=0x00, `busy_o`=0, `blk_done_tick_o`=0, `timeout_tick_o`=0, state=IDLE, and both ready signals follow the IDLE rules.
- `rst_i` asserted mid-transfer aborts the transfer on the next edge. No done or timeout tick is emitted.
- **Accept:** accept happens at clock edge N. `tx_start_o` is high during cycle N+1. `uart_tx` samples `tx_din_o` at edge N+2.
- **Byte-to-byte turnaround (GAP_CYCLES=0):** the done tick is seen at edge M, and the next `tx_start_o` is high during cycle M+1. `uart_tx` returns to its idle state at edge M, so the start is not missed.
- **Throughput:** one block occupies 16 UART frames plus 16 × (`GAP_CYCLES` + 1) controller cycles.
- **Re-accept after completion:** a new request can be accepted in the first IDLE cycle after completion, with no dead cycle.
- **Simultaneous events:**
  - A done tick and watchdog expiry in the same cycle: the done tick wins.
  - `blk_valid_i` rising while a byte is in flight: the block is accepted only after that byte finishes.

## Test plan
- **Single block, byte order and done tick:** block 0x00112233_44556677_8899AABB_CCDDEEFF, `MSB_FIRST`=1, behavioral `uart_tx` model → receiver decodes 00,11,…,FF in order; exactly 16 `tx_start_o` pulses; one `blk_done_tick_o` one cycle after the 16th done tick.
- **Byte order reversed:** same block with `MSB_FIRST`=0 → receiver decodes FF,EE,…,00.
- **Simultaneous requests:** `byte_valid_i` with 0xA5 and `blk_valid_i` raised in the same cycle → 0xA5 is sent first and the block follows immediately. A second byte request raised during the block waits until after `blk_done_tick_o`.
- **Byte gap:** `GAP_CYCLES`=5 → exactly 6 cycles from each done tick to the next `tx_start_o`.
- **Watchdog:** `TIMEOUT_CYCLES`=100 and the model never returns a done tick → `timeout_tick_o` at cycle 100 of WAIT, then IDLE with `busy_o`=0 and no `blk_done_tick_o`.
- **Reset mid-block:** `rst_i` asserted after byte 7 → all outputs at reset values on the next cycle. A fresh block then transmits all 16 bytes correctly.

Source files
------------

// File: rtl/aes_block_tx_ctrl.sv
// aes_block_tx_ctrl: schedules 128-bit AES result blocks and single status
// bytes onto a byte-wide uart_tx using its start/done-tick handshake. A block
// is always sent as 16 back-to-back bytes, never interleaved with status
// bytes. A watchdog abandons a transfer if the transmitter stops answering.
module aes_block_tx_ctrl #(
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 16384,
  parameter bit MSB_FIRST      = 1'b1
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         blk_valid_i,
  input  logic [127:0] blk_data_i,
  output logic         blk_ready_o,
  input  logic         byte_valid_i,
  input  logic [7:0]   byte_data_i,
  output logic         byte_ready_o,
  output logic [7:0]   tx_din_o,
  output logic         tx_start_o,
  input  logic         tx_done_tick_i,
  output logic         busy_o,
  output logic         blk_done_tick_o,
  output logic         timeout_tick_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_GAP
  } state_t;

  // A zero timeout turns the watchdog off; a zero gap skips the GAP state.
  localparam bit          WD_EN     = (TIMEOUT_CYCLES != 0);
  localparam bit          GAP_EN    = (GAP_CYCLES != 0);
  localparam logic [14:0] WD_LIMIT  = WD_EN  ? 15'(TIMEOUT_CYCLES - 1) : 15'd0;
  localparam logic [15:0] GAP_LIMIT = GAP_EN ? 16'(GAP_CYCLES - 1)     : 16'd0;

  state_t         r_state;
  state_t         w_nextState;
  logic [127:0]   r_shift;
  logic           r_isBlk;
  logic [3:0]     r_byteIdx;
  logic [14:0]    r_wdCnt;
  logic [15:0]    r_gapCnt;
  logic           r_blkDoneTick;
  logic           r_timeoutTick;

  logic           w_acceptByte;
  logic           w_acceptBlk;
  logic           w_lastByte;
  logic           w_wdExpire;
  logic           w_advance;
  logic           w_finish;
  logic           w_abort;

  // The status byte always wins a tie; the block keeps its data stable and waits.
  assign w_acceptByte = (r_state == ST_IDLE) && byte_valid_i;
  assign w_acceptBlk  = (r_state == ST_IDLE) && blk_valid_i && !byte_valid_i;

  // A lone status byte is always its own last byte; a block ends after byte 15.
  assign w_lastByte = !r_isBlk || (r_byteIdx == 4'd15);
  assign w_wdExpire = WD_EN && (r_wdCnt == WD_LIMIT);

  assign blk_ready_o     = (r_state == ST_IDLE) && !byte_valid_i;
  assign byte_ready_o    = (r_state == ST_IDLE);
  assign tx_start_o      = (r_state == ST_START);
  assign busy_o          = (r_state != ST_IDLE);
  assign blk_done_tick_o = r_blkDoneTick;
  assign timeout_tick_o  = r_timeoutTick;

  // Status bytes sit in the low byte, so only blocks sent MSB-first use the top byte.
  assign tx_din_o = (r_isBlk && MSB_FIRST) ? r_shift[127:120] : r_shift[7:0];

  // Next-state decode; a done tick takes priority over a simultaneous watchdog expiry.
  always_comb begin
    w_nextState = r_state;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acceptByte || w_acceptBlk) begin
          w_nextState = ST_START;
        end
      end
      ST_START: begin
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick_i) begin
          if (!w_lastByte) begin
            w_advance   = 1'b1;
            w_nextState = GAP_EN ? ST_GAP : ST_START;
          end else begin
            w_finish    = 1'b1;
            w_nextState = ST_IDLE;
          end
        end else if (w_wdExpire) begin
          w_abort     = 1'b1;
          w_nextState = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (r_gapCnt == GAP_LIMIT) begin
          w_nextState = ST_START;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Payload shift register and byte bookkeeping for the transfer in flight.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_shift   <= '0;
      r_isBlk   <= 1'b0;
      r_byteIdx <= 4'd0;
    end else if (w_acceptByte) begin
      r_shift   <= {120'd0, byte_data_i};
      r_isBlk   <= 1'b0;
      r_byteIdx <= 4'd0;
    end else if (w_acceptBlk) begin
      r_shift   <= blk_data_i;
      r_isBlk   <= 1'b1;
      r_byteIdx <= 4'd0;
    end else if (w_advance) begin
      r_shift   <= MSB_FIRST ? (r_shift << 8) : (r_shift >> 8);
      r_byteIdx <= r_byteIdx + 4'd1;
    end else if (w_abort) begin
      r_isBlk   <= 1'b0;
      r_byteIdx <= 4'd0;
    end
  end

  // Watchdog counts WAIT cycles, saturating, and restarts each time a byte is started.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_wdCnt <= 15'd0;
    end else if (w_nextState == ST_START) begin
      r_wdCnt <= 15'd0;
    end else if ((r_state == ST_WAIT) && (r_wdCnt != 15'h7FFF)) begin
      r_wdCnt <= r_wdCnt + 15'd1;
    end
  end

  // Counts the idle cycles spent in GAP between bytes of one block.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_gapCnt <= 16'd0;
    end else if (r_state != ST_GAP) begin
      r_gapCnt <= 16'd0;
    end else begin
      r_gapCnt <= r_gapCnt + 16'd1;
    end
  end

  // Completion and watchdog pulses, high in the first IDLE cycle after the transfer ends.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_blkDoneTick <= 1'b0;
      r_timeoutTick <= 1'b0;
    end else begin
      r_blkDoneTick <= w_finish && r_isBlk;
      r_timeoutTick <= w_abort;
    end
  end

endmodule

// File: tb/tb_aes_block_tx_ctrl.sv
// Testbench for aes_block_tx_ctrl. Two instances share one clock and reset:
// A sends MSB-first with no gap and a 100-cycle watchdog, B sends LSB-first
// with a 5-cycle gap and the watchdog disabled. Each has a behavioural
// uart_tx responder that records every started byte and its timing.
module tb_aes_block_tx_ctrl;

  localparam int FRAME = 4;
  localparam int GAP_B = 5;
  localparam int TO_A  = 100;
  localparam int BUFSZ = 1024;

  logic         clk = 1'b0;
  logic         rst;
  logic         blkValid[2];
  logic [127:0] blkData[2];
  logic         blkReady[2];
  logic         byteValid[2];
  logic [7:0]   byteData[2];
  logic         byteReady[2];
  logic [7:0]   txDin[2];
  logic         txStart[2];
  logic         txDone[2];
  logic         busy[2];
  logic         blkDoneTick[2];
  logic         timeoutTick[2];

  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  bit           stall[2];

  int           uCnt[2];
  int           rxCnt[2];
  logic [7:0]   rxBuf[2][BUFSZ];
  int           startCyc[2][BUFSZ];
  int           doneCyc[2][BUFSZ];
  int           lastDoneCyc[2];
  int           blkDoneCnt[2];
  int           blkDoneCyc[2];
  int           toCnt[2];
  int           toCyc[2];

  always #5 clk = ~clk;

  // Cycle number, advanced on every active edge.
  always @(posedge clk) cyc <= cyc + 1;

  aes_block_tx_ctrl #(
    .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO_A), .MSB_FIRST(1'b1)
  ) dutA (
    .clk(clk), .rst_i(rst),
    .blk_valid_i(blkValid[0]), .blk_data_i(blkData[0]), .blk_ready_o(blkReady[0]),
    .byte_valid_i(byteValid[0]), .byte_data_i(byteData[0]), .byte_ready_o(byteReady[0]),
    .tx_din_o(txDin[0]), .tx_start_o(txStart[0]), .tx_done_tick_i(txDone[0]),
    .busy_o(busy[0]), .blk_done_tick_o(blkDoneTick[0]), .timeout_tick_o(timeoutTick[0])
  );

  aes_block_tx_ctrl #(
    .GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(0), .MSB_FIRST(1'b0)
  ) dutB (
    .clk(clk), .rst_i(rst),
    .blk_valid_i(blkValid[1]), .blk_data_i(blkData[1]), .blk_ready_o(blkReady[1]),
    .byte_valid_i(byteValid[1]), .byte_data_i(byteData[1]), .byte_ready_o(byteReady[1]),
    .tx_din_o(txDin[1]), .tx_start_o(txStart[1]), .tx_done_tick_i(txDone[1]),
    .busy_o(busy[1]), .blk_done_tick_o(blkDoneTick[1]), .timeout_tick_o(timeoutTick[1])
  );

  // uart_tx stand-in plus monitors, evaluated on the falling edge away from the DUT edge.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      txDone[ch] = 1'b0;
      if (blkDoneTick[ch]) begin
        blkDoneCnt[ch]++;
        blkDoneCyc[ch] = cyc;
      end
      if (timeoutTick[ch]) begin
        toCnt[ch]++;
        toCyc[ch] = cyc;
      end
      if (rst) begin
        uCnt[ch] = 0;
      end else if (txStart[ch]) begin
        if (rxCnt[ch] < BUFSZ) begin
          rxBuf[ch][rxCnt[ch]]    = txDin[ch];
          startCyc[ch][rxCnt[ch]] = cyc;
        end
        rxCnt[ch]++;
        uCnt[ch] = FRAME;
      end else if (uCnt[ch] > 0) begin
        uCnt[ch]--;
        if (uCnt[ch] == 0 && !stall[ch]) begin
          txDone[ch]      = 1'b1;
          lastDoneCyc[ch] = cyc;
          if (rxCnt[ch] >= 1 && rxCnt[ch] <= BUFSZ) doneCyc[ch][rxCnt[ch] - 1] = cyc;
        end
      end
    end
  end

  // Reference: byte k of a block in transmit order for the given instance.
  function automatic logic [7:0] expByte(input int ch, input logic [127:0] blk, input int k);
    int sh;
    sh = (ch == 0) ? 8 * (15 - k) : 8 * k;
    return 8'(blk >> sh);
  endfunction

  function automatic int chGap(input int ch);
    return (ch == 0) ? 0 : GAP_B;
  endfunction

  function automatic logic [127:0] randBlk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise one request, hold it until the accepting edge, then drop it.
  task automatic applyStimulus(input int ch, input bit isBlk, input logic [127:0] data, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    if (isBlk) begin
      blkData[ch]  = data;
      blkValid[ch] = 1'b1;
    end else begin
      byteData[ch]  = data[7:0];
      byteValid[ch] = 1'b1;
    end
    for (int n = 0; n < 400; n++) begin
      #1;
      if (isBlk ? blkReady[ch] : byteReady[ch]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    blkValid[ch]  = 1'b0;
    byteValid[ch] = 1'b0;
  endtask

  task automatic checkResetOutputs(input int ch);
    checkOutput($sformatf("rst_busy%0d", ch), busy[ch], 1'b0);
    checkOutput($sformatf("rst_start%0d", ch), txStart[ch], 1'b0);
    checkOutput($sformatf("rst_din%0d", ch), txDin[ch], 8'h00);
    checkOutput($sformatf("rst_blkDone%0d", ch), blkDoneTick[ch], 1'b0);
    checkOutput($sformatf("rst_timeout%0d", ch), timeoutTick[ch], 1'b0);
    checkOutput($sformatf("rst_blkReady%0d", ch), blkReady[ch], 1'b1);
    checkOutput($sformatf("rst_byteReady%0d", ch), byteReady[ch], 1'b1);
  endtask

  task automatic runBlock(input int ch, input logic [127:0] blk);
    int r0;
    int d0;
    bit ok;
    r0 = rxCnt[ch];
    d0 = blkDoneCnt[ch];
    applyStimulus(ch, 1'b1, blk, ok);
    checkOutput("blkAccept", ok, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      if (blkDoneCnt[ch] != d0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("blkDoneSeen", ok, 1'b1);
    checkOutput("blkDoneDelay", blkDoneCyc[ch] - lastDoneCyc[ch], 1);
    checkOutput("busyAfterBlk", busy[ch], 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("blkDonePulses", blkDoneCnt[ch] - d0, 1);
    checkOutput("startPulses", rxCnt[ch] - r0, 16);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("ch%0d_byte%0d", ch, k), rxBuf[ch][r0 + k], expByte(ch, blk, k));
    end
    for (int k = 1; k < 16; k++) begin
      checkOutput($sformatf("ch%0d_gap%0d", ch, k),
                  startCyc[ch][r0 + k] - doneCyc[ch][r0 + k - 1], chGap(ch) + 1);
    end
  endtask

  task automatic sendByte(input int ch, input logic [7:0] b);
    int r0;
    int d0;
    bit ok;
    r0 = rxCnt[ch];
    d0 = blkDoneCnt[ch];
    applyStimulus(ch, 1'b0, {120'd0, b}, ok);
    checkOutput("byteAccept", ok, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!busy[ch]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("byteIdle", ok, 1'b1);
    checkOutput("byteCount", rxCnt[ch] - r0, 1);
    checkOutput("byteValue", rxBuf[ch][r0], b);
    checkOutput("byteNoBlkDone", blkDoneCnt[ch] - d0, 0);
  endtask

  initial begin
    int r0;
    int d0;
    int t0;
    bit ok;
    logic [127:0] rb;

    rst = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      blkValid[ch]  = 1'b0;
      blkData[ch]   = '0;
      byteValid[ch] = 1'b0;
      byteData[ch]  = 8'h00;
      stall[ch]     = 1'b0;
    end
    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkResetOutputs(0);
    checkResetOutputs(1);
    byteValid[0] = 1'b1;
    #1;
    checkOutput("rst_blkReadyWithByte", blkReady[0], 1'b0);
    checkOutput("rst_byteReadyWithByte", byteReady[0], 1'b1);
    byteValid[0] = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed block, both byte orders");
    runBlock(0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    runBlock(1, 128'h00112233_44556677_8899AABB_CCDDEEFF);

    $display("[TB] random blocks and status bytes");
    for (int i = 0; i < 3; i++) begin
      runBlock(0, randBlk());
      runBlock(1, randBlk());
      sendByte(0, 8'($urandom));
      sendByte(1, 8'($urandom));
    end

    $display("[TB] simultaneous byte and block requests");
    rb = randBlk();
    r0 = rxCnt[0];
    d0 = blkDoneCnt[0];
    @(negedge clk);
    byteData[0]  = 8'hA5;
    byteValid[0] = 1'b1;
    blkData[0]   = rb;
    blkValid[0]  = 1'b1;
    #1;
    checkOutput("simBlkReady", blkReady[0], 1'b0);
    checkOutput("simByteReady", byteReady[0], 1'b1);
    @(posedge clk);
    @(negedge clk);
    byteValid[0] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rxCnt[0] - r0 >= 2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("simBlkStarted", ok, 1'b1);
    blkValid[0] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rxCnt[0] - r0 >= 5) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("simMidBlock", ok, 1'b1);
    byteData[0]  = 8'h3C;
    byteValid[0] = 1'b1;
    #1;
    checkOutput("byteReadyDuringBlk", byteReady[0], 1'b0);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (rxCnt[0] - r0 >= 18) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("simSecondByteStarted", ok, 1'b1);
    byteValid[0] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!busy[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("simIdle", ok, 1'b1);
    checkOutput("simTotalBytes", rxCnt[0] - r0, 18);
    checkOutput("simBlkDonePulses", blkDoneCnt[0] - d0, 1);
    checkOutput("simFirstByte", rxBuf[0][r0], 8'hA5);
    checkOutput("simBlkFollows", startCyc[0][r0 + 1] - doneCyc[0][r0], 2);
    for (int k = 0; k < 16; k++) begin
      checkOutput($sformatf("simBlk_byte%0d", k), rxBuf[0][r0 + 1 + k], expByte(0, rb, k));
    end
    checkOutput("simBlkDoneDelay", blkDoneCyc[0] - doneCyc[0][r0 + 16], 1);
    checkOutput("simLastByte", rxBuf[0][r0 + 17], 8'h3C);
    checkOutput("simReacceptNoDead", startCyc[0][r0 + 17] - blkDoneCyc[0], 1);

    $display("[TB] watchdog expiry");
    stall[0] = 1'b1;
    r0 = rxCnt[0];
    d0 = blkDoneCnt[0];
    t0 = toCnt[0];
    applyStimulus(0, 1'b1, randBlk(), ok);
    checkOutput("wdAccept", ok, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (toCnt[0] != t0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("wdFired", ok, 1'b1);
    checkOutput("wdLatency", toCyc[0] - startCyc[0][r0], TO_A + 1);
    checkOutput("wdBusy", busy[0], 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("wdPulses", toCnt[0] - t0, 1);
    checkOutput("wdStarts", rxCnt[0] - r0, 1);
    checkOutput("wdNoBlkDone", blkDoneCnt[0] - d0, 0);
    stall[0] = 1'b0;
    sendByte(0, 8'h5A);

    $display("[TB] disabled watchdog, then reset mid-transfer");
    stall[1] = 1'b1;
    t0 = toCnt[1];
    applyStimulus(1, 1'b0, 128'h77, ok);
    checkOutput("noWdAccept", ok, 1'b1);
    repeat (300) @(negedge clk);
    checkOutput("noWdPulses", toCnt[1] - t0, 0);
    checkOutput("noWdStillBusy", busy[1], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs(1);
    rst = 1'b0;
    stall[1] = 1'b0;

    $display("[TB] reset mid-block");
    r0 = rxCnt[0];
    applyStimulus(0, 1'b1, randBlk(), ok);
    checkOutput("rstBlkAccept", ok, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (rxCnt[0] - r0 >= 8) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("rstReachedByte7", ok, 1'b1);
    d0 = blkDoneCnt[0];
    t0 = toCnt[0];
    rst = 1'b1;
    @(negedge clk);
    checkResetOutputs(0);
    rst = 1'b0;
    repeat (FRAME + 3) @(negedge clk);
    checkOutput("rstNoBlkDone", blkDoneCnt[0] - d0, 0);
    checkOutput("rstNoTimeout", toCnt[0] - t0, 0);
    checkOutput("rstStaysIdle", busy[0], 1'b0);
    runBlock(0, randBlk());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
